// File: rtl/conv_ctrl_pkg.sv
// Shared types and default geometry for the convolution controller.
package conv_ctrl_pkg;

   localparam int N_DEF = 16;
   localparam int M_DEF = 8;

   typedef enum logic [2:0] {
      LOAD_F,
      LOAD_X,
      COMPUTE,
      FLUSH,
      OUTPUT
   } state_t;

endpackage

// File: rtl/conv_ctrl_cnt.sv
// Saturating up-counter with clear and terminal-count flag.
// Clear has priority over enable. The counter stops at MAX and never wraps.
module conv_ctrl_cnt #(
   parameter int W   = 4,
   parameter int MAX = 15
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         tc
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && !tc)
         cnt <= cnt + W'(1);
   end

   assign tc = (cnt == MAX_V);

endmodule

// File: rtl/conv_ctrl_16_8.sv
// Sequencer for an M-tap convolution over an N-sample vector: loads taps and
// samples, sweeps the read addresses, and hands each result downstream.
// Define CONV_CTRL_FILTER_REUSE_EN to keep the taps between vectors.
//
// state   | meaning
// LOAD_F  | accept M taps into filter memory
// LOAD_X  | accept N samples into input memory
// COMPUTE | issue M reads for output k, one term j per cycle
// FLUSH   | last product lands in the accumulator
// OUTPUT  | result valid, wait for downstream handshake
module conv_ctrl_16_8
   import conv_ctrl_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int M = M_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 x_valid,
   output logic                 x_ready,
   output logic                 y_valid,
   input  logic                 y_ready,
   output logic                 f_wr_en,
   output logic [$clog2(M)-1:0] f_wr_addr,
   output logic                 x_wr_en,
   output logic [$clog2(N)-1:0] x_wr_addr,
   output logic [$clog2(M)-1:0] f_rd_addr,
   output logic [$clog2(N)-1:0] x_rd_addr,
   output logic                 acc_en,
   output logic                 acc_clr
);

   localparam int FA = $clog2(M);
   localparam int XA = $clog2(N);

`ifdef CONV_CTRL_FILTER_REUSE_EN
   localparam state_t DONE_NXT = LOAD_X;
`else
   localparam state_t DONE_NXT = LOAD_F;
`endif

   state_t state, state_nxt;

   logic [FA-1:0] tap, j;
   logic [XA-1:0] smp, k;
   logic tap_tc, smp_tc, j_tc, k_tc;
   logic tap_en, tap_clr, smp_en, smp_clr, j_en, j_clr, k_en, k_clr;

   conv_ctrl_cnt #(.W(FA), .MAX(M - 1)) u_tap (
      .clk(clk), .reset(reset), .en(tap_en), .clr(tap_clr), .cnt(tap), .tc(tap_tc)
   );

   conv_ctrl_cnt #(.W(XA), .MAX(N - 1)) u_smp (
      .clk(clk), .reset(reset), .en(smp_en), .clr(smp_clr), .cnt(smp), .tc(smp_tc)
   );

   conv_ctrl_cnt #(.W(FA), .MAX(M - 1)) u_j (
      .clk(clk), .reset(reset), .en(j_en), .clr(j_clr), .cnt(j), .tc(j_tc)
   );

   // k stops at N-M so that k+j never reaches past the last sample
   conv_ctrl_cnt #(.W(XA), .MAX(N - M)) u_k (
      .clk(clk), .reset(reset), .en(k_en), .clr(k_clr), .cnt(k), .tc(k_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= LOAD_F;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      x_ready   = 1'b0;
      y_valid   = 1'b0;
      f_wr_en   = 1'b0;
      x_wr_en   = 1'b0;
      tap_en    = 1'b0;
      tap_clr   = 1'b0;
      smp_en    = 1'b0;
      smp_clr   = 1'b0;
      j_en      = 1'b0;
      j_clr     = 1'b0;
      k_en      = 1'b0;
      k_clr     = 1'b0;
      case (state)
         LOAD_F: begin
            // reset parks the FSM here, so hold off the handshake until release
            x_ready = !reset;
            f_wr_en = x_valid && !reset;
            tap_en  = x_valid && !reset;
            if (x_valid && !reset && tap_tc) begin
               tap_clr   = 1'b1;
               state_nxt = LOAD_X;
            end
         end
         LOAD_X: begin
            x_ready = 1'b1;
            x_wr_en = x_valid;
            smp_en  = x_valid;
            if (x_valid && smp_tc) begin
               smp_clr   = 1'b1;
               state_nxt = COMPUTE;
            end
         end
         COMPUTE: begin
            j_en = 1'b1;
            if (j_tc) begin
               j_clr     = 1'b1;
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            state_nxt = OUTPUT;
         end
         OUTPUT: begin
            y_valid = 1'b1;
            if (y_ready) begin
               if (k_tc) begin
                  k_clr     = 1'b1;
                  state_nxt = DONE_NXT;
               end else begin
                  k_en      = 1'b1;
                  state_nxt = COMPUTE;
               end
            end
         end
         default: state_nxt = LOAD_F;
      endcase
   end

   // accumulate controls trail the read address by the memory latency
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_en  <= 1'b0;
         acc_clr <= 1'b0;
      end else begin
         acc_en  <= (state == COMPUTE);
         acc_clr <= (state == COMPUTE) && (j == '0);
      end
   end

   assign f_wr_addr = tap;
   assign x_wr_addr = smp;
   assign f_rd_addr = j;
   assign x_rd_addr = k + XA'(j);

endmodule

// File: tb/tb_conv_ctrl_16_8.sv
// Randomised bench for conv_ctrl_16_8 against a transaction-level expectation
// of load order, per-output read sweep, result timing and handshake count.
module tb_conv_ctrl_16_8;

   localparam int N    = 16;
   localparam int M    = 8;
   localparam int NOUT = N - M + 1;

`ifdef CONV_CTRL_FILTER_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       x_valid = 1'b0;
   logic       y_ready = 1'b0;
   logic       x_ready, y_valid, f_wr_en, x_wr_en, acc_en, acc_clr;
   logic [2:0] f_wr_addr, f_rd_addr;
   logic [3:0] x_wr_addr, x_rd_addr;

   int n_chk = 0;
   int n_bad = 0;

   conv_ctrl_16_8 #(.N(N), .M(M)) dut (
      .clk(clk), .reset(reset),
      .x_valid(x_valid), .x_ready(x_ready),
      .y_valid(y_valid), .y_ready(y_ready),
      .f_wr_en(f_wr_en), .f_wr_addr(f_wr_addr),
      .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr),
      .f_rd_addr(f_rd_addr), .x_rd_addr(x_rd_addr),
      .acc_en(acc_en), .acc_clr(acc_clr)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input bit xv, input bit yr);
      @(negedge clk);
      x_valid = xv;
      y_ready = yr;
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_xrdy"}, x_ready, 0);
      check_val({tag, "_yv"}, y_valid, 0);
      check_val({tag, "_wr"}, {f_wr_en, x_wr_en}, 0);
      check_val({tag, "_acc"}, {acc_en, acc_clr}, 0);
      check_val({tag, "_addr"}, {f_wr_addr, x_wr_addr, f_rd_addr, x_rd_addr}, 0);
   endtask

   // reset with x_valid/y_ready held high; both are dropped on release
   task automatic do_reset(input string tag);
      @(negedge clk);
      reset   = 1'b1;
      x_valid = 1'b1;
      y_ready = 1'b1;
      #1;
      check_all_zero(tag);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         check_all_zero(tag);
      end
      @(negedge clk);
      reset   = 1'b0;
      x_valid = 1'b0;
      y_ready = 1'b0;
      #1;
      check_val({tag, "_rel_xrdy"}, x_ready, 1);
   endtask

   // the i-th accepted word goes to tap i while i < nf, then to sample i-nf
   task automatic load_vector(input int nf, input bit rnd, output int cycles);
      int acc;
      int total;
      bit xv;
      acc    = 0;
      total  = nf + N;
      cycles = 0;
      while (acc < total && cycles < 400) begin
         xv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         step(xv, 1'($urandom_range(0, 1)));
         cycles++;
         check_val("ld_xrdy", x_ready, 1);
         check_val("ld_yv", y_valid, 0);
         check_val("ld_acc_en", acc_en, 0);
         if (xv) begin
            if (acc < nf) begin
               check_val("ld_f_wr_en", f_wr_en, 1);
               check_val("ld_f_wr_addr", f_wr_addr, acc);
               check_val("ld_x_wr_en", x_wr_en, 0);
            end else begin
               check_val("ld_x_wr_en", x_wr_en, 1);
               check_val("ld_x_wr_addr", x_wr_addr, acc - nf);
               check_val("ld_f_wr_en", f_wr_en, 0);
            end
            acc++;
         end else begin
            check_val("ld_idle_wr", {f_wr_en, x_wr_en}, 0);
         end
      end
      check_val("ld_count", acc, total);
   endtask

   // per output: M read cycles (tap j, sample k+j), one flush, then y_valid
   task automatic compute_vector(input bit rnd, input int hold_k, input int rst_k);
      int  hs;
      int  waits;
      bit  done;
      bit  yr;
      int  f_hold, x_hold;
      hs = 0;
      for (int k = 0; k < NOUT; k++) begin
         for (int j = 0; j < M; j++) begin
            if (k == rst_k && j == 3) begin
               do_reset("midrst");
               return;
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_val("cmp_xrdy", x_ready, 0);
            check_val("cmp_wr", {f_wr_en, x_wr_en}, 0);
            check_val("cmp_yv", y_valid, 0);
            check_val("cmp_f_rd", f_rd_addr, j);
            check_val("cmp_x_rd", x_rd_addr, k + j);
            check_val("cmp_acc_en", acc_en, (j > 0) ? 1 : 0);
            check_val("cmp_acc_clr", acc_clr, (j == 1) ? 1 : 0);
         end
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check_val("flush_yv", y_valid, 0);
         check_val("flush_acc_en", acc_en, 1);
         check_val("flush_acc_clr", acc_clr, 0);
         check_val("flush_xrdy", x_ready, 0);
         waits  = 0;
         done   = 1'b0;
         f_hold = 0;
         x_hold = 0;
         while (!done && waits < 64) begin
            if (k == hold_k)   yr = (waits >= 5);
            else if (rnd)      yr = 1'($urandom_range(0, 1));
            else               yr = 1'b1;
            step(1'($urandom_range(0, 1)), yr);
            check_val("out_yv", y_valid, 1);
            check_val("out_acc_en", acc_en, 0);
            check_val("out_xrdy", x_ready, 0);
            check_val("out_wr", {f_wr_en, x_wr_en}, 0);
            if (waits == 0) begin
               f_hold = f_rd_addr;
               x_hold = x_rd_addr;
            end else begin
               check_val("out_f_rd_stable", f_rd_addr, f_hold);
               check_val("out_x_rd_stable", x_rd_addr, x_hold);
            end
            if (yr) begin
               hs++;
               done = 1'b1;
            end
            waits++;
         end
         check_val("out_handshake", done, 1);
      end
      check_val("handshakes", hs, NOUT);
   endtask

   initial begin
      int cyc;
      reset = 1'b1;
      do_reset("por");

      load_vector(M, 1'b0, cyc);
      check_val("ld_directed_cycles", cyc, M + N);
      compute_vector(1'b0, 2, -1);

      load_vector(REUSE ? 0 : M, 1'b1, cyc);
      compute_vector(1'b1, -1, -1);

      load_vector(REUSE ? 0 : M, 1'b1, cyc);
      compute_vector(1'b1, -1, 4);

      load_vector(M, 1'b1, cyc);
      compute_vector(1'b1, 5, -1);

      load_vector(REUSE ? 0 : M, 1'b1, cyc);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/conv_ctrl_16_8.md
CONV_CTRL_16_8 -- requirements
Module: conv_ctrl_16_8

Interface
REQ-001 SHALL have parameter N, 16, input-vector length in samples.
REQ-002 SHALL have parameter M, 8, filter length in taps; M < N.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  input  1  one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port x_valid  input  1  upstream sample valid.
REQ-006 SHALL have port x_ready  output  1  controller accepts a sample this cycle.
REQ-007 SHALL have port y_valid  output  1  result in datapath accumulator is valid.
REQ-008 SHALL have port y_ready  input  1  downstream accepts result.
REQ-009 SHALL have ports f_wr_en (output, 1) and f_wr_addr (output, clog2(M)), the filter-memory write strobe and address.
REQ-010 SHALL have ports x_wr_en (output, 1) and x_wr_addr (output, clog2(N)), the input-memory write strobe and address.
REQ-011 SHALL have ports f_rd_addr (output, clog2(M)) and x_rd_addr (output, clog2(N)), the memory read addresses; memories have 1-cycle read latency.
REQ-012 SHALL have ports acc_en (output, 1) and acc_clr (output, 1): accumulate the product this cycle, and load the product instead of adding it.

Function
REQ-013 SHALL implement FSM states LOAD_F, LOAD_X, COMPUTE, FLUSH, OUTPUT.
REQ-014 In LOAD_F: x_ready=1; f_wr_en = x_valid; f_wr_addr = tap counter; the counter increments on each x_valid&&x_ready; the M-th accept moves to LOAD_X and zeroes the counter.
REQ-015 In LOAD_X: x_ready=1; x_wr_en = x_valid; x_wr_addr = sample counter; the N-th accept moves to COMPUTE with output index k=0 and term j=0.
REQ-016 x_ready SHALL be 0 in COMPUTE, FLUSH and OUTPUT; f_wr_en and x_wr_en SHALL be 0 outside their load states.
REQ-017 In COMPUTE: each cycle drive f_rd_addr=j and x_rd_addr=k+j, then increment j; after j=M-1 move to FLUSH.
REQ-018 acc_en and acc_clr SHALL be registered one cycle behind the read address: acc_en=1 in the cycle after each COMPUTE cycle; acc_clr=1 only in the cycle after j=0.
REQ-019 FLUSH SHALL last exactly one cycle (last accumulate) and then move to OUTPUT; per-output latency from COMPUTE entry to y_valid is M+1 cycles.
REQ-020 In OUTPUT: y_valid=1 and held until y_ready; acc_en=0; the state holds while !y_ready.
REQ-021 On y_valid&&y_ready with k<N-M: k increments, j=0, next state is COMPUTE.
REQ-022 On y_valid&&y_ready with k=N-M (N-M+1 outputs done): next state is LOAD_F (see REQ-028).
REQ-023 x_valid asserted outside the load states SHALL be ignored; it SHALL NOT advance any counter.
REQ-024 Counters SHALL NOT wrap within a phase; k+j SHALL never exceed N-1.

Reset
REQ-025 Asserting reset in any state, including mid-COMPUTE or OUTPUT, SHALL immediately force state LOAD_F with all counters 0.
REQ-026 During reset: x_ready=0, y_valid=0, f_wr_en=0, x_wr_en=0, acc_en=0, acc_clr=0, and all addresses 0. x_ready SHALL rise in the first cycle after reset deasserts.

Configuration
REQ-027 Macro CONV_CTRL_FILTER_REUSE_EN SHALL select the filter-reuse feature.
REQ-028 With the macro defined, REQ-022 SHALL go to LOAD_X, retaining the filter. Without it, REQ-022 SHALL go to LOAD_F. Reset SHALL go to LOAD_F in both builds.

Structure
REQ-029 Package conv_ctrl_pkg SHALL hold the state enum typedef and the default N and M constants.
REQ-030 A sub-module conv_ctrl_cnt (parameterised up-counter with enable, clear and terminal-count flag) SHALL be used for the tap, sample, j and k counters.

Verification
REQ-031 Reset, then feed 8 taps and 16 samples with x_valid always 1 -> f_wr_addr 0..7 then x_wr_addr 0..15 in 24 cycles, and x_ready=0 from cycle 25.
REQ-032 With y_ready always 1 -> 9 outputs; y_valid first seen 9 cycles after COMPUTE entry; x_rd_addr for output k=3 sweeps 3..10.
REQ-033 Hold y_ready=0 for 5 cycles in OUTPUT -> y_valid stays 1, state is stable, acc_en=0, and no address changes.
REQ-034 Randomise x_valid and y_ready at 50% -> all 24 writes land at correct addresses and exactly 9 handshakes occur per vector.
REQ-035 Assert reset during COMPUTE of output k=4 -> all outputs go to 0 at once; after release, a full 24-sample load is required again.
REQ-036 After output 9 -> the state is LOAD_F without CONV_CTRL_FILTER_REUSE_EN, and LOAD_X with it; in the macro build the next load is 16 samples only.
